// File: rtl/swing_conditioner.sv
// -----------------------------------------------------------------------------
// swing_conditioner
//
// Turns the two raw player push-buttons into clean, single-shot swing pulses
// for the ball block, and keeps a saturating swing count per player for the
// score/debug display.
//
// Each player has its own channel:
//   2-FF synchronizer -> press debounce -> fixed-width pulse -> release
//   debounce -> post-swing cooldown -> idle
// Holding, bouncing or repeatedly tapping a button yields at most one swing
// per press. The two channels are fully independent and have no arbitration.
//
// Ports (top):
//   clk              system clock, all logic on the rising edge
//   rst              synchronous active-low reset
//   btn_raw_one/two  asynchronous raw button inputs
//   enable           1 = new presses accepted (game active)
//   button_one/two   registered swing pulses, PULSE_CYCLES wide
//   swing_count_*    registered accepted-swing counts, saturating at 255
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// swing_channel
//
// One player's conditioning path. All outputs come straight from flops.
//
// Ports:
//   clk, rst    clock and synchronous active-low reset
//   i_raw       asynchronous raw button
//   i_enable    gates only the idle -> press-debounce transition
//   o_button    registered swing pulse
//   o_count     registered saturating swing count
// -----------------------------------------------------------------------------
module swing_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 8,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    input  logic       i_enable,
    output logic       o_button,
    output logic [7:0] o_count
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_FIRE       = 3'd2,
        ST_RELEASE_DB = 3'd3,
        ST_COOLDOWN   = 3'd4
    } state_t;

    // Terminal counts; each phase counts from 0 (or 1) up to its last value.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Saturating increment for the 8-bit swing count.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_button;
    logic [7:0]       r_count;

    // Two-stage synchronizer for the asynchronous raw button.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Channel FSM with registered pulse and swing-count outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= CNT_ZERO;
            r_button <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_button <= 1'b0;
                    if (r_sync2 && i_enable) begin
                        // This sample is the first of the press debounce run.
                        r_state <= ST_PRESS_DB;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end
                end

                ST_PRESS_DB: begin
                    if (!r_sync2 || !i_enable) begin
                        // Bounce or game paused: abandon without a pulse.
                        r_state  <= ST_IDLE;
                        r_cnt    <= CNT_ZERO;
                        r_button <= 1'b0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state  <= ST_FIRE;
                        r_cnt    <= CNT_ZERO;
                        r_button <= 1'b1;
                        r_count  <= sat_inc8(r_count);
                    end else begin
                        r_state  <= ST_PRESS_DB;
                        r_cnt    <= r_cnt + CNT_ONE;
                        r_button <= 1'b0;
                    end
                end

                ST_FIRE: begin
                    // Pulse width is fixed; button level and enable are ignored.
                    if (r_cnt == PULSE_LAST) begin
                        r_state  <= ST_RELEASE_DB;
                        r_cnt    <= CNT_ZERO;
                        r_button <= 1'b0;
                    end else begin
                        r_state  <= ST_FIRE;
                        r_cnt    <= r_cnt + CNT_ONE;
                        r_button <= 1'b1;
                    end
                end

                ST_RELEASE_DB: begin
                    r_button <= 1'b0;
                    if (r_sync2) begin
                        // Still held (or bouncing): restart the low-run count.
                        r_state <= ST_RELEASE_DB;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= ST_COOLDOWN;
                        r_cnt   <= CNT_ZERO;
                    end else begin
                        r_state <= ST_RELEASE_DB;
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end

                ST_COOLDOWN: begin
                    r_button <= 1'b0;
                    if (r_cnt == COOL_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end else begin
                        r_state <= ST_COOLDOWN;
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= CNT_ZERO;
                    r_button <= 1'b0;
                end
            endcase
        end
    end

    assign o_button = r_button;
    assign o_count  = r_count;

endmodule

// -----------------------------------------------------------------------------
// swing_conditioner (top): two independent player channels.
// -----------------------------------------------------------------------------
module swing_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 8,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw_one,
    input  logic       btn_raw_two,
    input  logic       enable,
    output logic       button_one,
    output logic       button_two,
    output logic [7:0] swing_count_one,
    output logic [7:0] swing_count_two
);

    logic       w_button_one;
    logic       w_button_two;
    logic [7:0] w_count_one;
    logic [7:0] w_count_two;

    swing_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PULSE_CYCLES    (PULSE_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_one (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (btn_raw_one),
        .i_enable (enable),
        .o_button (w_button_one),
        .o_count  (w_count_one)
    );

    swing_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PULSE_CYCLES    (PULSE_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_two (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (btn_raw_two),
        .i_enable (enable),
        .o_button (w_button_two),
        .o_count  (w_count_two)
    );

    // Channel outputs are already flop outputs; pass them straight through.
    assign button_one      = w_button_one;
    assign button_two      = w_button_two;
    assign swing_count_one = w_count_one;
    assign swing_count_two = w_count_two;

endmodule

// File: tb/tb_swing_conditioner.sv
// -----------------------------------------------------------------------------
// tb_swing_conditioner: directed, self-checking bench for swing_conditioner.
// Edge numbering: edge 1 is the first rising edge at which a raw input is
// sampled high. Inputs change and outputs are sampled 1 time unit after edges.
// -----------------------------------------------------------------------------
module tb_swing_conditioner;

    logic       clk;
    logic       rst;
    logic       btn_raw_one;
    logic       btn_raw_two;
    logic       enable;
    logic       button_one;
    logic       button_two;
    logic [7:0] swing_count_one;
    logic [7:0] swing_count_two;

    int n_cmp;
    int n_err;

    swing_conditioner dut (
        .clk             (clk),
        .rst             (rst),
        .btn_raw_one     (btn_raw_one),
        .btn_raw_two     (btn_raw_two),
        .enable          (enable),
        .button_one      (button_one),
        .button_two      (button_two),
        .swing_count_one (swing_count_one),
        .swing_count_two (swing_count_two)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_raw_one = 1'b0;
        btn_raw_two = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({button_one, button_two, swing_count_one, swing_count_two} !== 18'd0) begin
                n_err++;
                $display("FAIL reset_hold: got b1=%b b2=%b c1=%0d c2=%0d, want all 0",
                         button_one, button_two, swing_count_one, swing_count_two);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            n_cmp++;
            if ({button_one, button_two, swing_count_one, swing_count_two} !== 18'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got b1=%b b2=%b c1=%0d c2=%0d, want all 0",
                         i, button_one, button_two, swing_count_one, swing_count_two);
            end
        end
    endtask

    // 5-cycle press on player one: pulse after edges 6..13, count becomes 1.
    task automatic test_clean_press();
        logic exp_b;
        btn_raw_one = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 5) btn_raw_one = 1'b0;
            exp_b = (e >= 6 && e <= 13);
            n_cmp++;
            if (button_one !== exp_b || button_two !== 1'b0) begin
                n_err++;
                $display("FAIL clean_press edge %0d: got b1=%b b2=%b, want b1=%b b2=0",
                         e, button_one, button_two, exp_b);
            end
        end
        n_cmp++;
        if (swing_count_one !== 8'd1 || swing_count_two !== 8'd0) begin
            n_err++;
            $display("FAIL clean_count: got c1=%0d c2=%0d, want 1 0", swing_count_one, swing_count_two);
        end
        idle(40);
    endtask

    // 1,1,0 repeating never gives 4 consecutive highs: no pulse, count stays 1.
    task automatic test_bounce();
        for (int i = 0; i < 40; i++) begin
            btn_raw_one = ((i % 3) != 2);
            step();
            n_cmp++;
            if (button_one !== 1'b0) begin
                n_err++;
                $display("FAIL bounce cyc %0d: got b1=%b, want 0", i, button_one);
            end
        end
        btn_raw_one = 1'b0;
        idle(40);
        n_cmp++;
        if (swing_count_one !== 8'd1) begin
            n_err++;
            $display("FAIL bounce_count: got %0d, want 1", swing_count_one);
        end
    endtask

    task automatic test_hold_cooldown();
        int  rises_hold, highs_hold, rises_a, rises_b, highs_b;
        logic prev;
        rises_hold = 0; highs_hold = 0; rises_a = 0; rises_b = 0; highs_b = 0;
        prev = 1'b0;
        btn_raw_one = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (button_one) highs_hold++;
            if (button_one && !prev) rises_hold++;
            prev = button_one;
        end
        n_cmp++;
        if (rises_hold != 1 || highs_hold != 8) begin
            n_err++;
            $display("FAIL hold_pulse: got %0d pulses %0d high cycles, want 1 and 8",
                     rises_hold, highs_hold);
        end
        // t = 0 is the first edge sampling the release; re-presses at t=10 and t=30.
        for (int t = 0; t < 90; t++) begin
            btn_raw_one = (t >= 10 && t <= 14) || (t >= 30 && t <= 34);
            step();
            if (t < 30) begin
                if (button_one && !prev) rises_a++;
            end else begin
                if (button_one) highs_b++;
                if (button_one && !prev) rises_b++;
            end
            prev = button_one;
        end
        btn_raw_one = 1'b0;
        n_cmp++;
        if (rises_a != 0) begin
            n_err++;
            $display("FAIL cooldown_reject: got %0d pulses, want 0", rises_a);
        end
        n_cmp++;
        if (rises_b != 1 || highs_b != 8) begin
            n_err++;
            $display("FAIL cooldown_repress: got %0d pulses %0d high, want 1 and 8", rises_b, highs_b);
        end
        n_cmp++;
        if (swing_count_one !== 8'd3) begin
            n_err++;
            $display("FAIL hold_count: got %0d, want 3", swing_count_one);
        end
    endtask

    task automatic test_simultaneous();
        logic exp_b;
        btn_raw_one = 1'b1;
        btn_raw_two = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 5) begin
                btn_raw_one = 1'b0;
                btn_raw_two = 1'b0;
            end
            exp_b = (e >= 6 && e <= 13);
            n_cmp++;
            if (button_one !== exp_b || button_two !== exp_b) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: got b1=%b b2=%b, want both %b",
                         e, button_one, button_two, exp_b);
            end
        end
        idle(40);
        n_cmp++;
        if (swing_count_one !== 8'd4 || swing_count_two !== 8'd1) begin
            n_err++;
            $display("FAIL simultaneous_count: got c1=%0d c2=%0d, want 4 1",
                     swing_count_one, swing_count_two);
        end
    endtask

    task automatic test_enable_off();
        enable = 1'b0;
        btn_raw_one = 1'b1;
        btn_raw_two = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                btn_raw_one = 1'b0;
                btn_raw_two = 1'b0;
            end
            step();
            n_cmp++;
            if (button_one !== 1'b0 || button_two !== 1'b0) begin
                n_err++;
                $display("FAIL enable_off cyc %0d: got b1=%b b2=%b, want 0 0", i, button_one, button_two);
            end
        end
        enable = 1'b1;
        idle(5);
        n_cmp++;
        if (swing_count_one !== 8'd4 || swing_count_two !== 8'd1) begin
            n_err++;
            $display("FAIL enable_off_count: got c1=%0d c2=%0d, want 4 1",
                     swing_count_one, swing_count_two);
        end
    endtask

    // enable dropped after edge 7 (in FIRE): pulse still spans edges 6..13.
    task automatic test_enable_drop_fire();
        logic exp_b;
        btn_raw_one = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 5) btn_raw_one = 1'b0;
            if (e == 7) enable = 1'b0;
            exp_b = (e >= 6 && e <= 13);
            n_cmp++;
            if (button_one !== exp_b) begin
                n_err++;
                $display("FAIL enable_drop edge %0d: got b1=%b, want %b", e, button_one, exp_b);
            end
        end
        enable = 1'b1;
        idle(40);
        n_cmp++;
        if (swing_count_one !== 8'd5) begin
            n_err++;
            $display("FAIL enable_drop_count: got %0d, want 5", swing_count_one);
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 260; p++) begin
            btn_raw_two = 1'b1;
            idle(5);
            btn_raw_two = 1'b0;
            idle(35);
            if (p == 253) begin
                n_cmp++;
                if (swing_count_two !== 8'd255) begin
                    n_err++;
                    $display("FAIL sat_254th: got %0d, want 255", swing_count_two);
                end
            end
        end
        n_cmp++;
        if (swing_count_two !== 8'd255 || swing_count_one !== 8'd5) begin
            n_err++;
            $display("FAIL saturation: got c2=%0d c1=%0d, want 255 5", swing_count_two, swing_count_one);
        end
    endtask

    // Reset on the 4th edge of the pulse (after 3 high cycles) drops it at once.
    task automatic test_reset_mid_pulse();
        btn_raw_two = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 5) btn_raw_two = 1'b0;
        end
        n_cmp++;
        if (button_two !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pulse_pre: got b2=%b, want 1", button_two);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (button_two !== 1'b0 || swing_count_two !== 8'd0 || swing_count_one !== 8'd0) begin
            n_err++;
            $display("FAIL mid_pulse_reset: got b2=%b c2=%0d c1=%0d, want 0 0 0",
                     button_two, swing_count_two, swing_count_one);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (button_two !== 1'b0 || swing_count_two !== 8'd0) begin
                n_err++;
                $display("FAIL post_reset cyc %0d: got b2=%b c2=%0d, want 0 0",
                         i, button_two, swing_count_two);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        btn_raw_one = 1'b0;
        btn_raw_two = 1'b0;
        enable = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_cooldown();
        test_simultaneous();
        test_enable_off();
        test_enable_drop_fire();
        test_saturation();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
